// File: rtl/pkmc_sdramctrl_cmdseq.sv
// SDRAM command sequencer: power-up init, periodic auto-refresh and single-burst
// read/write accesses with auto-precharge, emitting registered one-cycle command strobes.
module pkmc_sdramctrl_cmdseq #(
  parameter int unsigned ADDRLEN      = 26,
  parameter int unsigned T_INIT       = 20000,
  parameter int unsigned T_RP         = 3,
  parameter int unsigned T_RFC        = 7,
  parameter int unsigned T_MRD        = 2,
  parameter int unsigned T_RCD        = 3,
  parameter int unsigned CAS_LAT      = 2,
  parameter int unsigned BURST_LEN    = 4,
  parameter int unsigned T_WR         = 2,
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [ADDRLEN-1:0] addr_i,
  output logic [ADDRLEN-1:0] addr_o,
  output logic               prechCmd_o,
  output logic               activeCmd_o,
  output logic               readCmd_o,
  output logic               writeCmd_o,
  output logic               lmrCmd_o,
  output logic               refCmd_o,
  output logic               apc_o,
  output logic               all_one_o,
  output logic               wrData_o,
  output logic               rdValid_o,
  output logic               ack_o,
  output logic               initDone_o
);

  // Tail lengths: counter value loaded with the READ/WRITE command so that it reaches 0 in
  // the cycle that decides the next command.
  localparam int unsigned RdTail = CAS_LAT + BURST_LEN + T_RP - 1;
  localparam int unsigned WrTail = BURST_LEN + T_WR + T_RP - 2;
  localparam int unsigned Max0   = (T_INIT > REF_INTERVAL) ? T_INIT : REF_INTERVAL;
  localparam int unsigned Max1   = (Max0 > RdTail + 1) ? Max0 : RdTail + 1;
  localparam int unsigned CntMax = (Max1 > WrTail + 1) ? Max1 : WrTail + 1;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [3:0] {
    StInitWait, StInitPre, StInitRef1, StInitRef2, StInitLmr,
    StIdle, StRefWait, StActWait, StRead, StWrite
  } state_e;

  typedef enum logic [2:0] {
    CmdNone, CmdPre, CmdAct, CmdRd, CmdWr, CmdLmr, CmdRef
  } cmd_e;

  state_e             state_q, state_d;
  cmd_e               cmd;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [CntW-1:0]    ref_cnt_q, ref_cnt_d;
  logic               ref_pend_q, ref_pend_d;
  logic               we_q, we_d;
  logic [ADDRLEN-1:0] addr_q, addr_d;
  logic               cnt_zero, ref_tick, ref_due, decide;

  logic prech_d, act_d, rd_d, wr_d, lmr_d, ref_d, apc_d, all_one_d;
  logic wrdata_d, rdvalid_d, ack_d, init_done_d;
  logic prech_q, act_q, rd_q, wr_q, lmr_q, ref_q, apc_q, all_one_q;
  logic wrdata_q, rdvalid_q, ack_q, init_done_q;

  assign cnt_zero = (cnt_q == '0);
  assign ref_tick = init_done_q && (ref_cnt_q == '0);
  assign ref_due  = ref_pend_q || ref_tick;
  // The final wait cycle after a refresh or an access doubles as an IDLE decision slot.
  assign decide   = (state_q == StIdle) ||
                    (cnt_zero && (state_q inside {StRefWait, StRead, StWrite}));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StInitWait;
      cnt_q       <= CntW'(T_INIT - 1);
      ref_cnt_q   <= CntW'(REF_INTERVAL - 1);
      ref_pend_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      prech_q     <= 1'b0;
      act_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      lmr_q       <= 1'b0;
      ref_q       <= 1'b0;
      apc_q       <= 1'b0;
      all_one_q   <= 1'b0;
      wrdata_q    <= 1'b0;
      rdvalid_q   <= 1'b0;
      ack_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      prech_q     <= prech_d;
      act_q       <= act_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      lmr_q       <= lmr_d;
      ref_q       <= ref_d;
      apc_q       <= apc_d;
      all_one_q   <= all_one_d;
      wrdata_q    <= wrdata_d;
      rdvalid_q   <= rdvalid_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd        = CmdNone;
    we_d       = we_q;
    addr_d     = addr_q;
    ref_pend_d = ref_pend_q || ref_tick;
    ref_cnt_d  = ref_cnt_q;

    if (init_done_q) begin
      ref_cnt_d = (ref_cnt_q == '0) ? CntW'(REF_INTERVAL - 1) : ref_cnt_q - CntW'(1);
    end

    case (state_q)
      StInitWait: begin
        if (cnt_zero) begin
          cmd     = CmdPre;
          cnt_d   = CntW'(T_RP - 1);
          state_d = StInitPre;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StInitPre: begin
        if (cnt_zero) begin
          cmd     = CmdRef;
          cnt_d   = CntW'(T_RFC - 1);
          state_d = StInitRef1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StInitRef1: begin
        if (cnt_zero) begin
          cmd     = CmdRef;
          cnt_d   = CntW'(T_RFC - 1);
          state_d = StInitRef2;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StInitRef2: begin
        if (cnt_zero) begin
          cmd     = CmdLmr;
          cnt_d   = CntW'(T_MRD - 1);
          state_d = StInitLmr;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StInitLmr: begin
        if (cnt_zero) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StActWait: begin
        if (cnt_zero) begin
          cmd     = we_q ? CmdWr : CmdRd;
          cnt_d   = we_q ? CntW'(WrTail) : CntW'(RdTail);
          state_d = we_q ? StWrite : StRead;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRefWait, StRead, StWrite: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StIdle: ;
      default: state_d = StInitWait;
    endcase

    // Refresh always wins over a waiting request.
    if (decide) begin
      if (ref_due) begin
        cmd        = CmdRef;
        cnt_d      = CntW'(T_RFC - 1);
        state_d    = StRefWait;
        ref_pend_d = 1'b0;
      end else if (req_i) begin
        cmd     = CmdAct;
        addr_d  = addr_i;
        we_d    = we_i;
        cnt_d   = CntW'(T_RCD - 1);
        state_d = StActWait;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    prech_d     = (cmd == CmdPre);
    act_d       = (cmd == CmdAct);
    rd_d        = (cmd == CmdRd);
    wr_d        = (cmd == CmdWr);
    lmr_d       = (cmd == CmdLmr);
    ref_d       = (cmd == CmdRef);
    apc_d       = rd_d || wr_d;
    all_one_d   = prech_d;
    wrdata_d    = wr_d || ((state_q == StWrite) && (cnt_q >= CntW'(T_WR + T_RP)));
    rdvalid_d   = (state_q == StRead) && (cnt_q > CntW'(T_RP)) &&
                  (cnt_q <= CntW'(T_RP + BURST_LEN));
    ack_d       = ((state_q == StRead) && (cnt_q == CntW'(T_RP))) ||
                  ((state_q == StWrite) && (cnt_q == CntW'(T_WR + T_RP - 1)));
    init_done_d = init_done_q || ((state_q == StInitLmr) && cnt_zero);
  end

  assign addr_o      = addr_q;
  assign prechCmd_o  = prech_q;
  assign activeCmd_o = act_q;
  assign readCmd_o   = rd_q;
  assign writeCmd_o  = wr_q;
  assign lmrCmd_o    = lmr_q;
  assign refCmd_o    = ref_q;
  assign apc_o       = apc_q;
  assign all_one_o   = all_one_q;
  assign wrData_o    = wrdata_q;
  assign rdValid_o   = rdvalid_q;
  assign ack_o       = ack_q;
  assign initDone_o  = init_done_q;

endmodule

// File: doc/pkmc_sdramctrl_cmdseq.md
Name: pkmc_sdramctrl_cmdseq

Overview:
- SDRAM command sequencer. Sits directly upstream of the SDRAM address generator inside the PKMC SDRAM controller.
- Accepts single-burst read/write requests from the memory-controller front end and runs the power-up init sequence plus periodic auto-refresh.
- Emits one-cycle command strobes (precharge/active/read/write/LMR/refresh), the apc/all_one qualifiers, a latched request address, and data-phase enables.
- Every access uses auto-precharge, so all banks are idle whenever the FSM is in IDLE.

Parameters:
- ADDRLEN, 26, width of request address; bank select is addr[25:24].
- T_INIT, 20000, cycles from reset release to the first PRECHARGE-all.
- T_RP, 3, cycles from PRECHARGE to the next command.
- T_RFC, 7, cycles from REFRESH to the next command.
- T_MRD, 2, cycles from LMR to the next command.
- T_RCD, 3, cycles from ACTIVE to READ/WRITE.
- CAS_LAT, 2, cycles from READ to the first read beat.
- BURST_LEN, 4, data beats per access (1..8).
- T_WR, 2, write recovery cycles after the last write beat.
- REF_INTERVAL, 780, cycles between refresh requests.

Ports:
- clk_i  in  1  controller clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_i  in  1  access request; level, held until ack_o.
- we_i  in  1  1=write, 0=read; sampled with req_i.
- addr_i  in  ADDRLEN  request address; sampled with req_i.
- addr_o  out  ADDRLEN  latched request address, drives the address generator.
- prechCmd_o  out  1  PRECHARGE strobe.
- activeCmd_o  out  1  ACTIVE strobe.
- readCmd_o  out  1  READ strobe.
- writeCmd_o  out  1  WRITE strobe.
- lmrCmd_o  out  1  LOAD MODE REGISTER strobe.
- refCmd_o  out  1  AUTO REFRESH strobe.
- apc_o  out  1  auto-precharge qualifier; 1 coincident with readCmd_o and writeCmd_o.
- all_one_o  out  1  precharge-all qualifier; 1 coincident with prechCmd_o.
- wrData_o  out  1  write beat enable (drive DQ).
- rdValid_o  out  1  read beat valid (capture DQ).
- ack_o  out  1  one-cycle access-complete pulse.
- initDone_o  out  1  high once init is complete.

Behaviour:
- Reset (async, rst_n_i=0): all outputs 0, addr_o=0. FSM goes to INIT_WAIT; wait counter loads T_INIT-1; refresh counter loads REF_INTERVAL-1; ref_pend clears.
- Reset mid-operation: aborts immediately and restarts the full init sequence.
- Registered outputs: all strobes are registered and high for exactly one cycle. At most one command strobe is high in any cycle.
- Command spacing: after issuing a command with timing N, the next command strobe appears exactly N cycles later (wait counter loads N-1 and counts to 0).
- Init sequence:
  - INIT_WAIT (T_INIT) -> INIT_PRE: prechCmd_o with all_one_o=1, then wait T_RP.
  - -> INIT_REF1: refCmd_o, then wait T_RFC.
  - -> INIT_REF2: refCmd_o, then wait T_RFC.
  - -> INIT_LMR: lmrCmd_o, then wait T_MRD.
  - -> IDLE, with initDone_o=1 from that cycle on.
  - req_i is ignored until IDLE.
- Refresh counter:
  - Runs only after initDone_o. At 0 it sets ref_pend and reloads.
  - If ref_pend is already set, the reload still occurs; a second pending refresh is not queued.
- IDLE priority is ref_pend, then req_i:
  - If ref_pend: refCmd_o, clear ref_pend, wait T_RFC, return to IDLE.
  - Else if req_i: latch addr_i->addr_o and we_i, issue activeCmd_o, wait T_RCD.
  - req_i simultaneous with ref_pend: the refresh is served first and req_i is accepted afterward.
- Access, read:
  - readCmd_o with apc_o=1.
  - rdValid_o high for BURST_LEN consecutive cycles, starting CAS_LAT cycles after the readCmd_o cycle.
  - ack_o in the cycle after the last beat.
  - Then T_RP-1 further cycles, then IDLE.
- Access, write:
  - writeCmd_o with apc_o=1; wrData_o high in the same cycle and for the next BURST_LEN-1 cycles.
  - ack_o in the cycle after the last beat.
  - IDLE is reached T_WR+T_RP cycles after the last beat.
- Request timing:
  - ack_o is never asserted without a prior accepted request.
  - req_i deasserted before ack_o is a protocol violation; the access still completes and acks.
  - A new request is accepted only in IDLE; a request held across ack_o is not re-accepted before IDLE.
- ref_pend set mid-access: served at the next IDLE, ahead of any waiting req_i.
- Widths: counters are wide enough for max(T_INIT, REF_INTERVAL); wrap-around never occurs because they reload at 0.

Test Plan:
- Reset release, default parameters -> prechCmd_o+all_one_o at cycle 20000, refCmd_o at 20003 and 20010, lmrCmd_o at 20017, initDone_o=1 at 20019; no other strobes.
- After init, read addr_i=0x2ABCDE0 -> activeCmd_o at T; readCmd_o+apc_o at T+3; rdValid_o high T+5..T+8; ack_o at T+9; addr_o=0x2ABCDE0 throughout.
- Write: activeCmd_o at T -> writeCmd_o+apc_o and wrData_o at T+3; wrData_o high T+3..T+6; ack_o at T+7; next activeCmd_o no earlier than T+11 with req_i held.
- req_i asserted in the same IDLE cycle that ref_pend sets -> refCmd_o first, activeCmd_o 7 cycles later; refCmd_o strobes spaced 780 cycles apart under idle traffic.
- Refresh interval expiring mid-read -> the access completes unchanged; refCmd_o issues in the first IDLE cycle after recovery.
- rst_n_i pulsed low during a write burst -> all outputs 0 immediately; full init sequence re-runs; no ack_o is emitted for the aborted access.
